// File: rtl/rob.sv
// Reorder buffer: in-order retirement of out-of-order results with branch mispredict flush.
// Macros: ROB_WIDTH (index width, default 3); ROB_BYPASS_EN forwards same-cycle writeback to search ports.
`ifndef ROB_WIDTH
`define ROB_WIDTH 3
`endif

module rob (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  issue_valid,
  input  logic [4:0]            issue_rd,
  input  logic                  issue_is_branch,
  input  logic                  issue_pred_taken,
  input  logic [31:0]           issue_alt_pc,
  input  logic                  issue_ready,
  input  logic [31:0]           issue_val,
  output logic [`ROB_WIDTH-1:0] issue_rob_id,
  output logic                  full,
  input  logic                  wb_valid,
  input  logic [`ROB_WIDTH-1:0] wb_rob_id,
  input  logic [31:0]           wb_val,
  input  logic                  wb_taken,
  output logic [4:0]            commit_reg_id,
  output logic [31:0]           commit_val,
  output logic [`ROB_WIDTH-1:0] commit_rob_id,
  input  logic [`ROB_WIDTH-1:0] search_rob_id_1,
  input  logic [`ROB_WIDTH-1:0] search_rob_id_2,
  output logic                  search_ready_1,
  output logic                  search_ready_2,
  output logic [31:0]           search_val_1,
  output logic [31:0]           search_val_2,
  output logic                  clear,
  output logic [31:0]           clear_pc
);
  localparam int unsigned W = `ROB_WIDTH;
  localparam int unsigned N = 1 << W;
  localparam logic [W:0]  DEPTH = (W+1)'(N);

  logic [W-1:0] head, tail;
  logic [W:0]   count;
  logic [N-1:0] busy, ready, is_br, pred, taken;
  logic [31:0]  val_q [N];
  logic [31:0]  alt_q [N];
  logic [4:0]   rd_q  [N];
  logic         do_issue, do_wb, do_commit, mispredict;

  assign full         = (count == DEPTH);
  assign issue_rob_id = tail;
  assign do_issue     = issue_valid && !full && !clear;
  assign do_wb        = wb_valid && !clear && busy[wb_rob_id];
  assign do_commit    = busy[head] && ready[head] && !clear;
  assign mispredict   = do_commit && is_br[head] && (taken[head] != pred[head]);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      busy          <= '0;
      ready         <= '0;
      is_br         <= '0;
      pred          <= '0;
      taken         <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        val_q[i] <= '0;
        alt_q[i] <= '0;
        rd_q[i]  <= '0;
      end
      commit_reg_id <= '0;
      commit_val    <= '0;
      commit_rob_id <= '0;
      clear         <= 1'b0;
      clear_pc      <= '0;
    end else if (rdy_in) begin
      commit_reg_id <= '0;
      clear         <= 1'b0;
      if (do_issue) begin
        busy[tail]  <= 1'b1;
        ready[tail] <= issue_ready;
        val_q[tail] <= issue_val;
        rd_q[tail]  <= issue_rd;
        is_br[tail] <= issue_is_branch;
        pred[tail]  <= issue_pred_taken;
        // An already-resolved branch is assumed to follow its prediction.
        taken[tail] <= issue_pred_taken;
        alt_q[tail] <= issue_alt_pc;
        tail        <= tail + W'(1);
      end
      if (do_wb) begin
        ready[wb_rob_id] <= 1'b1;
        val_q[wb_rob_id] <= wb_val;
        taken[wb_rob_id] <= wb_taken;
      end
      if (do_commit) begin
        busy[head] <= 1'b0;
        head       <= head + W'(1);
        if (!is_br[head]) begin
          commit_reg_id <= rd_q[head];
          commit_val    <= val_q[head];
          commit_rob_id <= head;
        end
      end
      count <= count + (W+1)'(do_issue) - (W+1)'(do_commit);
      // Flush overrides the pointer and busy updates above; stored ready/val survive.
      if (mispredict) begin
        busy     <= '0;
        head     <= '0;
        tail     <= '0;
        count    <= '0;
        clear    <= 1'b1;
        clear_pc <= alt_q[head];
      end
    end
  end

  always_comb begin
    search_ready_1 = ready[search_rob_id_1];
    search_val_1   = val_q[search_rob_id_1];
    search_ready_2 = ready[search_rob_id_2];
    search_val_2   = val_q[search_rob_id_2];
`ifdef ROB_BYPASS_EN
    if (wb_valid && wb_rob_id == search_rob_id_1) begin
      search_ready_1 = 1'b1;
      search_val_1   = wb_val;
    end
    if (wb_valid && wb_rob_id == search_rob_id_2) begin
      search_ready_2 = 1'b1;
      search_val_2   = wb_val;
    end
`endif
  end

endmodule

// File: tb/tb_rob.sv
// Scoreboard bench for rob: queue-based program-order model, monitor checks retire/flush events.
`ifndef ROB_WIDTH
`define ROB_WIDTH 3
`endif

module tb_rob;
  localparam int W = `ROB_WIDTH;
  localparam int N = 1 << W;

  logic          clk_in = 1'b0;
  logic          rst_in, rdy_in;
  logic          issue_valid, issue_is_branch, issue_pred_taken, issue_ready;
  logic [4:0]    issue_rd;
  logic [31:0]   issue_alt_pc, issue_val;
  logic [W-1:0]  issue_rob_id;
  logic          full;
  logic          wb_valid, wb_taken;
  logic [W-1:0]  wb_rob_id;
  logic [31:0]   wb_val;
  logic [4:0]    commit_reg_id;
  logic [31:0]   commit_val;
  logic [W-1:0]  commit_rob_id;
  logic [W-1:0]  search_rob_id_1, search_rob_id_2;
  logic          search_ready_1, search_ready_2;
  logic [31:0]   search_val_1, search_val_2;
  logic          clear;
  logic [31:0]   clear_pc;

  rob dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_is_branch(issue_is_branch),
    .issue_pred_taken(issue_pred_taken), .issue_alt_pc(issue_alt_pc),
    .issue_ready(issue_ready), .issue_val(issue_val),
    .issue_rob_id(issue_rob_id), .full(full),
    .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_val(wb_val), .wb_taken(wb_taken),
    .commit_reg_id(commit_reg_id), .commit_val(commit_val), .commit_rob_id(commit_rob_id),
    .search_rob_id_1(search_rob_id_1), .search_rob_id_2(search_rob_id_2),
    .search_ready_1(search_ready_1), .search_ready_2(search_ready_2),
    .search_val_1(search_val_1), .search_val_2(search_val_2),
    .clear(clear), .clear_pc(clear_pc)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int          edge_no;
    bit          is_clr;
    logic [4:0]  rd;
    logic [31:0] val;
    int          id;
  } ev_t;

  int  n_tests = 0;
  int  n_fail  = 0;
  int  edge_cnt = 0;
  bit  last_act = 1'b0;
  bit  mon_skip = 1'b1;
  ev_t sb[$];

  // Reference model: outstanding ids in program order plus per-id entry contents.
  int          q[$];
  bit          m_ready [N];
  logic [31:0] m_val   [N];
  logic [31:0] m_alt   [N];
  logic [4:0]  m_rd    [N];
  bit          m_br [N], m_pred [N], m_taken [N];
  int          m_tail;
  bit          m_clr;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_cnt);
    end
  endfunction

  function automatic void model_reset();
    q.delete();
    for (int i = 0; i < N; i++) begin
      m_ready[i] = 1'b0; m_val[i] = '0; m_alt[i] = '0; m_rd[i] = '0;
      m_br[i] = 1'b0; m_pred[i] = 1'b0; m_taken[i] = 1'b0;
    end
    m_tail = 0;
    m_clr  = 1'b0;
  endfunction

  function automatic void model_step();
    bit full_pre, busy_wb, flush;
    int cid;
    if (m_clr) begin
      m_clr = 1'b0;
      return;
    end
    full_pre = (q.size() == N);
    busy_wb  = 1'b0;
    foreach (q[i]) if (q[i] == int'(wb_rob_id)) busy_wb = 1'b1;
    flush = 1'b0;
    if (q.size() > 0 && m_ready[q[0]]) begin
      cid = q.pop_front();
      if (m_br[cid]) begin
        if (m_taken[cid] != m_pred[cid]) begin
          flush = 1'b1;
          sb.push_back('{edge_cnt, 1'b1, 5'd0, m_alt[cid], 0});
        end
      end else if (m_rd[cid] != 5'd0) begin
        sb.push_back('{edge_cnt, 1'b0, m_rd[cid], m_val[cid], cid});
      end
    end
    if (issue_valid && !full_pre) begin
      m_ready[m_tail] = issue_ready;
      m_val[m_tail]   = issue_val;
      m_rd[m_tail]    = issue_rd;
      m_br[m_tail]    = issue_is_branch;
      m_pred[m_tail]  = issue_pred_taken;
      m_taken[m_tail] = issue_pred_taken;
      m_alt[m_tail]   = issue_alt_pc;
      q.push_back(m_tail);
      m_tail = (m_tail + 1) % N;
    end
    if (wb_valid && busy_wb) begin
      m_ready[wb_rob_id] = 1'b1;
      m_val[wb_rob_id]   = wb_val;
      m_taken[wb_rob_id] = wb_taken;
    end
    if (flush) begin
      q.delete();
      m_tail = 0;
      m_clr  = 1'b1;
    end
  endfunction

  task automatic check_comb();
    bit          er1, er2;
    logic [31:0] ev1, ev2;
    chk("full", 32'(full), 32'(q.size() == N));
    chk("issue_rob_id", 32'(issue_rob_id), 32'(m_tail));
    er1 = m_ready[search_rob_id_1]; ev1 = m_val[search_rob_id_1];
    er2 = m_ready[search_rob_id_2]; ev2 = m_val[search_rob_id_2];
`ifdef ROB_BYPASS_EN
    if (wb_valid && wb_rob_id == search_rob_id_1) begin er1 = 1'b1; ev1 = wb_val; end
    if (wb_valid && wb_rob_id == search_rob_id_2) begin er2 = 1'b1; ev2 = wb_val; end
`endif
    chk("search_ready_1", 32'(search_ready_1), 32'(er1));
    chk("search_ready_2", 32'(search_ready_2), 32'(er2));
    if (er1) chk("search_val_1", search_val_1, ev1);
    if (er2) chk("search_val_2", search_val_2, ev2);
  endtask

  task automatic idle();
    rdy_in = 1'b1; issue_valid = 1'b0; issue_rd = '0; issue_is_branch = 1'b0;
    issue_pred_taken = 1'b0; issue_alt_pc = '0; issue_ready = 1'b0; issue_val = '0;
    wb_valid = 1'b0; wb_rob_id = '0; wb_val = '0; wb_taken = 1'b0;
    search_rob_id_1 = '0; search_rob_id_2 = W'(N-1);
  endtask

  task automatic set_issue(input logic [4:0] rd, input bit rdy, input logic [31:0] v,
                           input bit br, input bit pt, input logic [31:0] alt);
    issue_valid = 1'b1; issue_rd = rd; issue_ready = rdy; issue_val = v;
    issue_is_branch = br; issue_pred_taken = pt; issue_alt_pc = alt;
  endtask

  task automatic set_wb(input int id, input logic [31:0] v, input bit t);
    wb_valid = 1'b1; wb_rob_id = W'(id); wb_val = v; wb_taken = t;
  endtask

  // Called at a falling edge with inputs driven; returns at the next falling edge.
  task automatic tick();
    #1 check_comb();
    @(posedge clk_in);
    edge_cnt++;
    last_act = rdy_in && rst_in;
    if (last_act) model_step();
    @(negedge clk_in);
  endtask

  task automatic reset_checks();
    chk("rst_commit_reg_id", 32'(commit_reg_id), 32'd0);
    chk("rst_commit_val", commit_val, 32'd0);
    chk("rst_commit_rob_id", 32'(commit_rob_id), 32'd0);
    chk("rst_clear", 32'(clear), 32'd0);
    chk("rst_clear_pc", clear_pc, 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_issue_rob_id", 32'(issue_rob_id), 32'd0);
    chk("rst_search_ready_1", 32'(search_ready_1), 32'd0);
  endtask

  task automatic mid_reset();
    idle();
    #2 mon_skip = 1'b1;
    rst_in = 1'b0;
    #1 reset_checks();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_pending_at_reset: got %0d events expected 0", sb.size());
    end
    sb.delete();
    model_reset();
    @(posedge clk_in);
    last_act = 1'b0;
    @(negedge clk_in);
    #2 rst_in = 1'b1;
    mon_skip = 1'b0;
  endtask

  // Monitor: matches registered retire/flush outputs against the scoreboard.
  initial begin : monitor
    logic [4:0]  p_rd;
    logic [31:0] p_val, p_pc;
    logic [W-1:0] p_id;
    logic        p_clr;
    ev_t         e;
    p_rd = '0; p_val = '0; p_pc = '0; p_id = '0; p_clr = 1'b0;
    forever begin
      @(negedge clk_in);
      if (!mon_skip && rst_in) begin
        if (!last_act) begin
          chk("hold_commit_reg_id", 32'(commit_reg_id), 32'(p_rd));
          chk("hold_commit_val", commit_val, p_val);
          chk("hold_commit_rob_id", 32'(commit_rob_id), 32'(p_id));
          chk("hold_clear", 32'(clear), 32'(p_clr));
          chk("hold_clear_pc", clear_pc, p_pc);
        end else begin
          while (sb.size() > 0 && sb[0].edge_no < edge_cnt) begin
            n_tests++; n_fail++;
            $display("FAIL missed_event: got nothing expected event from edge %0d", sb[0].edge_no);
            void'(sb.pop_front());
          end
          if (commit_reg_id != 5'd0 || clear) begin
            if (sb.size() == 0) begin
              n_tests++; n_fail++;
              $display("FAIL unexpected_event: got rd=%0d clear=%0d expected none (edge %0d)",
                       commit_reg_id, clear, edge_cnt);
            end else begin
              e = sb.pop_front();
              chk("event_edge", 32'(edge_cnt), 32'(e.edge_no));
              chk("event_clear", 32'(clear), 32'(e.is_clr));
              if (e.is_clr) begin
                chk("clear_pc", clear_pc, e.val);
                chk("clear_commit_reg_id", 32'(commit_reg_id), 32'd0);
              end else begin
                chk("commit_reg_id", 32'(commit_reg_id), 32'(e.rd));
                chk("commit_val", commit_val, e.val);
                chk("commit_rob_id", 32'(commit_rob_id), 32'(e.id));
              end
            end
          end else if (sb.size() > 0 && sb[0].edge_no == edge_cnt) begin
            n_tests++; n_fail++;
            $display("FAIL missing_event: got nothing expected event at edge %0d", edge_cnt);
            void'(sb.pop_front());
          end
        end
      end
      p_rd = commit_reg_id; p_val = commit_val; p_id = commit_rob_id;
      p_clr = clear; p_pc = clear_pc;
    end
  end

  initial begin : driver
    int bid;
    rst_in = 1'b0;
    idle();
    model_reset();
    #3 reset_checks();
    @(negedge clk_in);
    #2 rst_in = 1'b1;
    mon_skip = 1'b0;

    // Ready-at-issue entry retires one cycle later.
    set_issue(5'd5, 1'b1, 32'h11, 1'b0, 1'b0, 32'h0); tick();
    idle(); tick(); tick();

    // Fill, refuse at full, out-of-order writeback, in-order retire, tail wrap.
    mid_reset();
    for (int i = 0; i < N; i++) begin
      idle(); set_issue(5'(i + 1), 1'b0, 32'(i), 1'b0, 1'b0, 32'h0); tick();
    end
    idle(); set_issue(5'd9, 1'b1, 32'h99, 1'b0, 1'b0, 32'h0); tick();
    idle(); set_wb(1, 32'hB1, 1'b0); tick();
    idle(); set_wb(0, 32'hB0, 1'b0); tick();
    idle(); tick(); tick();
    idle(); set_issue(5'd12, 1'b1, 32'hC0, 1'b0, 1'b0, 32'h0); tick();
    for (int i = 2; i < N; i++) begin
      idle(); set_wb(i, 32'hD0 + 32'(i), 1'b0); tick();
    end
    idle(); for (int i = 0; i < N + 2; i++) tick();

    // Mispredicted branch flushes younger ready entries.
    bid = m_tail;
    idle(); set_issue(5'd0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h100); tick();
    idle(); set_issue(5'd3, 1'b1, 32'h33, 1'b0, 1'b0, 32'h0); tick();
    idle(); set_issue(5'd4, 1'b1, 32'h44, 1'b0, 1'b0, 32'h0); tick();
    idle(); set_wb(bid, 32'h0, 1'b1); tick();
    idle(); for (int i = 0; i < 4; i++) tick();

    // Search of a pending entry around its writeback.
    for (int i = 0; i < 3; i++) begin
      idle(); set_issue(5'(20 + i), 1'b0, 32'hE0, 1'b0, 1'b0, 32'h0); tick();
    end
    idle(); search_rob_id_1 = W'(2); set_wb(2, 32'h2A, 1'b0); tick();
    idle(); search_rob_id_1 = W'(2); tick();
    idle(); set_wb(0, 32'hF0, 1'b0); tick();
    idle(); set_wb(1, 32'hF1, 1'b0); tick();
    idle(); for (int i = 0; i < 4; i++) tick();

    // Stall with a ready head, then resume.
    idle(); set_issue(5'd7, 1'b1, 32'h77, 1'b0, 1'b0, 32'h0); tick();
    idle(); rdy_in = 1'b0; tick(); tick(); tick();
    idle(); tick(); tick();

    // Reset with entries outstanding; nothing may retire afterwards.
    idle(); set_issue(5'd8, 1'b0, 32'h88, 1'b0, 1'b0, 32'h0); tick();
    idle(); set_issue(5'd9, 1'b1, 32'h99, 1'b0, 1'b0, 32'h0); tick();
    mid_reset();
    idle(); for (int i = 0; i < 4; i++) tick();

    // Randomised traffic.
    for (int c = 0; c < 1200; c++) begin
      idle();
      rdy_in = ($urandom_range(9) != 0);
      if ($urandom_range(1) == 1)
        set_issue(5'($urandom_range(31)), ($urandom_range(2) == 0), $urandom,
                  ($urandom_range(3) == 0), 1'($urandom_range(1)), $urandom);
      if ($urandom_range(9) < 5) begin
        if (q.size() > 0 && $urandom_range(3) != 0)
          set_wb(q[$urandom_range(q.size() - 1)], $urandom, 1'($urandom_range(1)));
        else
          set_wb(int'($urandom_range(N - 1)), $urandom, 1'($urandom_range(1)));
      end
      search_rob_id_1 = W'($urandom_range(N - 1));
      search_rob_id_2 = W'($urandom_range(N - 1));
      tick();
      if (c == 600) mid_reset();
    end

    // Drain outstanding entries with correct-direction writebacks.
    for (int k = 0; k < 4 * N + 8 && (q.size() > 0 || m_clr); k++) begin
      idle();
      if (q.size() > 0) set_wb(q[0], $urandom, m_pred[q[0]]);
      tick();
    end
    idle(); tick(); tick();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_empty_at_end: got %0d events expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
